// File: rtl/sxga_pkg.sv
// Shared SXGA definitions: video timing, SRAM field widths
// and the write-buffer state encoding.
package sxga_pkg;

  localparam int HSYNC    = 112;
  localparam int HBACK    = 248;
  localparam int HVISIBLE = 1280;
  localparam int HTOTAL   = 1688;
  localparam int VSYNC    = 3;
  localparam int VBACK    = 38;
  localparam int VVISIBLE = 1024;
  localparam int VTOTAL   = 1066;

  localparam int ADDR_W  = 19;
  localparam int PAGE_W  = 8;
  localparam int DATA_W  = 8;
  localparam int ENTRY_W = PAGE_W + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RECOVER = 2'd2
  } wr_state_t;

endpackage

// File: rtl/sxga_wr_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit
// so full/empty fall out of a plain pointer compare.
module sxga_wr_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign dout  = mem[rp[AW-1:0]];

  // Full is judged before the same-edge pop, so a write
  // into a full FIFO is dropped even while it drains.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      if (push_ok && !pop_ok)
        level <= level + 1'b1;
      else if (!push_ok && pop_ok)
        level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/sxga_wr_buf.sv
// Host write buffer feeding the SXGA video/SRAM write port;
// drains only during blanking with a minimum strobe spacing.
module sxga_wr_buf
  import sxga_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [18:0]            h_addr,
  input  logic [7:0]             h_page,
  input  logic [7:0]             h_data,
  input  logic                   h_we,
  output logic                   h_full,
  output logic                   h_ovf,
  input  logic                   h_ovf_clr,
  input  logic                   blank,
  output logic [18:0]            waddr,
  output logic [7:0]             srpage,
  output logic [7:0]             wdata,
  output logic                   wstb,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic [3:0] RCV_LAST =
    (GAP > 2) ? 4'(GAP - 3) : 4'd0;

  wr_state_t          state;
  wr_state_t          state_n;
  logic [3:0]         cnt;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;

  sxga_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (h_we),
    .din   ({h_page, h_addr, h_data}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign h_full = full;
  assign wstb   = (state == WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == WRITE)
        cnt <= RCV_LAST;
      else if (state == RECOVER)
        cnt <= cnt - 1'b1;
    end
  end

  // blank only gates the start of a strobe; WRITE always completes.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && blank) begin
          pop     = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE:   state_n = (GAP > 2) ? RECOVER : IDLE;
      RECOVER: if (cnt == 4'd0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr  <= '0;
      srpage <= '0;
      wdata  <= '0;
    end else if (pop) begin
      {srpage, waddr, wdata} <= head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      h_ovf <= 1'b0;
    else if (h_we && full)
      h_ovf <= 1'b1;
    else if (h_ovf_clr)
      h_ovf <= 1'b0;
  end

endmodule

// File: doc/sxga_wr_buf.md
Name: sxga_wr_buf

Overview:
- Write-side buffer directly upstream of the SXGA video/SRAM stage.
- Accepts byte writes from the host bus into a FIFO. Drains them to the video stage's write port (waddr/srpage/wstb plus wdata) only while the video stage reports the SRAM free (blanking).
- Spaces writes so the SRAM write-enable never stays low across an address change.
- Reports back-pressure and a sticky overflow flag to the host.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..64
GAP, 2, minimum cycles from one wstb pulse to the next; 2..8

Ports:
clk  in  1  system clock, also the video pixel clock
rst  in  1  reset
h_addr  in  19  host byte address; bit 0 selects the byte lane
h_page  in  8  host SRAM page
h_data  in  8  host write byte
h_we  in  1  single-cycle write request
h_full  out  1  FIFO full; host must not assert h_we
h_ovf  out  1  sticky overflow flag
h_ovf_clr  in  1  clears h_ovf
blank  in  1  high when the video stage is not fetching (~hfetch), so the SRAM is free
waddr  out  19  write address to the video stage
srpage  out  8  write page to the video stage
wdata  out  8  write byte, valid while wstb is high
wstb  out  1  single-cycle write strobe
level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is asynchronous and active-high. Port names: clk, rst.
- Reset values: wstb=0, waddr=0, srpage=0, wdata=0, h_ovf=0, level=0, h_full=0, FSM=IDLE, FIFO pointers=0.
- Reset asserted mid-operation discards all queued entries. A wstb that is high drops asynchronously.
- FIFO:
  - Each entry is {page[7:0], addr[18:0], data[7:0]}, 35 bits.
  - Circular buffer with read/write pointers one bit wider than the index; full/empty come from the pointer MSB compare.
  - Push: on an edge with h_we=1 and full=0, measured before any pop on the same edge.
  - h_we while full: the write is dropped and h_ovf is set. The drop happens even if a pop occurs on the same edge.
  - Simultaneous push and pop when not full: both happen and level is unchanged.
  - h_full = full, registered, consistent with level==DEPTH.
- Overflow flag:
  - h_ovf_clr clears h_ovf.
  - If h_ovf_clr and an overflowing h_we land on the same edge, set wins.
- FSM states: IDLE, WRITE, RECOVER.
  - IDLE: if not empty and blank=1, pop the head, register waddr/srpage/wdata from it, set wstb=1 and go to WRITE. Otherwise wstb=0 and stay.
  - WRITE: wstb is high for exactly this one cycle. Next edge: wstb=0. Go to RECOVER if GAP>2, else to IDLE.
  - RECOVER: counter of GAP-2 cycles, then IDLE.
  - Minimum wstb period is GAP cycles (GAP=2 gives a strobe every other cycle).
  - waddr/srpage/wdata hold their last values outside WRITE.
- Blank handling:
  - blank is sampled only in IDLE.
  - A strobe already issued completes even if blank falls during WRITE. The video stage gives wstb priority, so this costs at most one fetch slot at the edge of the visible area.
- Latency: push on edge N into an empty FIFO with blank=1 → wstb is high during the cycle after edge N+1 (registered; two edges).
- Ordering: strict FIFO order. No coalescing of writes to the same address.
- level: registered occupancy, updated on the same edge as push/pop.

Decomposition:
- Shared package `sxga_pkg`:
  - Timing localparams now embedded in the video stage (HSYNC, HBACK, HVISIBLE, HTOTAL, VSYNC, VBACK, VVISIBLE, VTOTAL).
  - SRAM field widths: ADDR_W=19, PAGE_W=8, DATA_W=8.
  - FSM state encodings IDLE/WRITE/RECOVER.
- Sub-module `sxga_wr_fifo`: generic synchronous FIFO (WIDTH, DEPTH; push/pop/full/empty/level, async active-high rst).
- The top holds the FSM, gap counter and overflow flag.

Test Plan:
- Reset, blank=1, one write {addr=0x00ABC, page=0x12, data=0x5A} → wstb high exactly one cycle, two edges after the push, with waddr=0x00ABC, srpage=0x12, wdata=0x5A; level returns to 0.
- blank=0, push 5 entries; raise blank after 20 cycles → no wstb while blank=0; then 5 strobes in push order, spaced 2 cycles apart (GAP=2).
- blank=0, push DEPTH+1 entries → h_full=1 after entry 16; entry 17 is dropped, h_ovf=1; pulse h_ovf_clr → h_ovf=0; drain yields exactly 16 writes.
- FIFO full, h_we and a pop on the same edge → new entry dropped, h_ovf=1, level=15 after the edge.
- blank toggling 1,0,0,1 across cycles with 3 entries queued → a strobe issued in IDLE completes after blank falls; no new strobe starts while blank=0.
- Assert rst while 8 entries are queued and wstb is high → wstb=0 immediately, level=0; no strobes after release until a new push.
